// File: rtl/prio_arb_pkg.sv
// Shared constants and helpers for the prio_arb_enc arbiter.
package prio_arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width that never collapses to zero bits.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/prio_find_high.sv
// Combinational highest-set-bit search over an N-bit vector.
module prio_find_high import prio_arb_pkg::*; #(
   parameter int N     = 16,
   parameter int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prio_arb_enc.sv
// Registered N-way priority arbiter with fixed / round-robin modes and a
// valid/ready grant handshake.
module prio_arb_enc import prio_arb_pkg::*; #(
   parameter int N     = 16,
   parameter int IDX_W = idx_width(N),
   parameter bit RR_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             mode,
   output logic             grant_valid,
   input  logic             grant_ready,
   output logic [IDX_W-1:0] grant_idx,
   output logic [N-1:0]     grant_onehot,
   output logic             none
);

   logic             gv_q, gv_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N-1:0]     oh_q, oh_d;
   logic             none_q, none_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             rr_q, rr_d;

   logic             slot;
   logic             use_rr;
   logic             hs_rr;
   logic [IDX_W-1:0] ptr_adv;
   logic [IDX_W-1:0] ptr_eff;
   logic [N-1:0]     mask;
   logic [IDX_W-1:0] u_idx, m_idx, win;
   logic             u_found, m_found;

   assign slot   = !gv_q || grant_ready;
   assign use_rr = RR_EN && (mode == MODE_RR);
   assign hs_rr  = gv_q && grant_ready && rr_q;

   // Accepting an RR grant rotates the pointer before this slot arbitrates,
   // so back-to-back grants see the updated priority.
   assign ptr_adv = (idx_q == '0) ? IDX_W'(N - 1) : idx_q - 1'b1;
   assign ptr_eff = hs_rr ? ptr_adv : ptr_q;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i <= int'(ptr_eff));
      end
   end

   prio_find_high #(.N(N), .IDX_W(IDX_W)) u_unmasked (
      .vec   (req),
      .idx   (u_idx),
      .found (u_found)
   );

   if (RR_EN) begin : g_rr
      prio_find_high #(.N(N), .IDX_W(IDX_W)) u_masked (
         .vec   (req & mask),
         .idx   (m_idx),
         .found (m_found)
      );
   end else begin : g_fixed
      assign m_idx   = '0;
      assign m_found = 1'b0;
   end

   assign win = (use_rr && m_found) ? m_idx : u_idx;

   always_comb begin
      gv_d   = gv_q;
      idx_d  = idx_q;
      oh_d   = oh_q;
      none_d = none_q;
      rr_d   = rr_q;
      ptr_d  = ptr_eff;
      if (slot) begin
         if (u_found) begin
            gv_d   = 1'b1;
            idx_d  = win;
            oh_d   = {{(N-1){1'b0}}, 1'b1} << win;
            none_d = 1'b0;
            rr_d   = use_rr;
         end else begin
            gv_d   = 1'b0;
            oh_d   = '0;
            none_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gv_q   <= 1'b0;
         idx_q  <= '0;
         oh_q   <= '0;
         none_q <= 1'b1;
         ptr_q  <= IDX_W'(N - 1);
         rr_q   <= 1'b0;
      end else begin
         gv_q   <= gv_d;
         idx_q  <= idx_d;
         oh_q   <= oh_d;
         none_q <= none_d;
         ptr_q  <= ptr_d;
         rr_q   <= rr_d;
      end
   end

   assign grant_valid  = gv_q;
   assign grant_idx    = idx_q;
   assign grant_onehot = oh_q;
   assign none         = none_q;

endmodule

// File: tb/tb_prio_arb_enc.sv
// Bench for prio_arb_enc: directed vector table, hand sequences and random
// traffic against a behavioural arbitration model, on N=16 and N=5 instances.
module tb_prio_arb_enc;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst16 = 1'b1, mode16 = 1'b0, rdy16 = 1'b0;
   logic [15:0] req16 = '0;
   logic        gv16, none16;
   logic [3:0]  idx16;
   logic [15:0] oh16;

   logic        rst5 = 1'b1, mode5 = 1'b0, rdy5 = 1'b0;
   logic [4:0]  req5 = '0;
   logic        gv5, none5;
   logic [2:0]  idx5;
   logic [4:0]  oh5;

   prio_arb_enc #(.N(16)) dut16 (
      .clk(clk), .rst(rst16), .req(req16), .mode(mode16),
      .grant_valid(gv16), .grant_ready(rdy16), .grant_idx(idx16),
      .grant_onehot(oh16), .none(none16)
   );

   prio_arb_enc #(.N(5)) dut5 (
      .clk(clk), .rst(rst5), .req(req5), .mode(mode5),
      .grant_valid(gv5), .grant_ready(rdy5), .grant_idx(idx5),
      .grant_onehot(oh5), .none(none5)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural model state, index 0 = N16 instance, 1 = N5 instance.
   int nn[2]    = '{16, 5};
   bit mgv[2];
   int midx[2];
   bit mnone[2];
   int mptr[2];
   bit mrr[2];

   typedef struct {
      logic [15:0] req;
      bit          mode;
      bit          rdy;
      bit          rst;
      bit          exp_gv;
      int          exp_idx;
      bit          exp_none;
   } vec_t;

   vec_t tbl[$];

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Winner search: walk priority order starting at the top (fixed) or at p (RR).
   function automatic int ref_winner(input int n, input logic [63:0] r, input bit rr, input int p);
      int start = rr ? p : n - 1;
      for (int k = 0; k < n; k++) begin
         int j = (start - k + n) % n;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_step(input int d, input logic [63:0] r, input bit md, input bit rdy, input bit rs);
      int w;
      if (rs) begin
         mgv[d] = 0; midx[d] = 0; mnone[d] = 1; mptr[d] = nn[d] - 1; mrr[d] = 0;
         return;
      end
      if (mgv[d] && !rdy) return;
      if (mgv[d] && mrr[d]) mptr[d] = (midx[d] == 0) ? nn[d] - 1 : midx[d] - 1;
      w = ref_winner(nn[d], r, md, mptr[d]);
      if (w >= 0) begin
         mgv[d] = 1; midx[d] = w; mnone[d] = 0; mrr[d] = md;
      end else begin
         mgv[d] = 0; mnone[d] = 1;
      end
   endtask

   task automatic check_model(input int d, input string nm);
      logic [63:0] a_gv, a_idx, a_oh, a_none, e_oh;
      if (d == 0) begin a_gv = gv16; a_idx = idx16; a_oh = oh16; a_none = none16; end
      else        begin a_gv = gv5;  a_idx = idx5;  a_oh = oh5;  a_none = none5;  end
      e_oh = mgv[d] ? (64'd1 << midx[d]) : 64'd0;
      cmp({nm, ".valid"},  a_gv,   64'(mgv[d]));
      cmp({nm, ".idx"},    a_idx,  64'(midx[d]));
      cmp({nm, ".onehot"}, a_oh,   e_oh);
      cmp({nm, ".none"},   a_none, 64'(mnone[d]));
   endtask

   // One clock on instance d; the other instance is parked in reset.
   task automatic step(input int d, input logic [63:0] r, input bit md, input bit rdy,
                       input bit rs, input string nm);
      if (d == 0) begin
         req16 = r[15:0]; mode16 = md; rdy16 = rdy; rst16 = rs; rst5 = 1'b1;
      end else begin
         req5 = r[4:0]; mode5 = md; rdy5 = rdy; rst5 = rs; rst16 = 1'b1;
      end
      @(posedge clk);
      #1;
      model_step(0, 64'(req16), mode16, rdy16, rst16);
      model_step(1, 64'(req5),  mode5,  rdy5,  rst5);
      check_model(d, nm);
   endtask

   task automatic check_exp(input int d, input bit gv, input int idx, input bit nn_o, input string nm);
      if (d == 0) begin
         cmp({nm, ".exp_valid"},  64'(gv16),   64'(gv));
         cmp({nm, ".exp_idx"},    64'(idx16),  64'(idx));
         cmp({nm, ".exp_onehot"}, 64'(oh16),   gv ? (64'd1 << idx) : 64'd0);
         cmp({nm, ".exp_none"},   64'(none16), 64'(nn_o));
      end else begin
         cmp({nm, ".exp_valid"},  64'(gv5),    64'(gv));
         cmp({nm, ".exp_idx"},    64'(idx5),   64'(idx));
         cmp({nm, ".exp_onehot"}, 64'(oh5),    gv ? (64'd1 << idx) : 64'd0);
         cmp({nm, ".exp_none"},   64'(none5),  64'(nn_o));
      end
   endtask

   function automatic vec_t mk(input logic [15:0] r, input bit md, input bit rdy, input bit rs,
                               input bit gv, input int idx, input bit nn_o);
      vec_t v;
      v.req = r; v.mode = md; v.rdy = rdy; v.rst = rs;
      v.exp_gv = gv; v.exp_idx = idx; v.exp_none = nn_o;
      return v;
   endfunction

   initial begin
      // reset with all requests asserted, then first grant
      tbl.push_back(mk(16'hFFFF, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(16'hFFFF, 0, 1, 1, 0, 0, 1));
      tbl.push_back(mk(16'hFFFF, 0, 1, 0, 1, 15, 0));
      // fixed priority, steady stream
      for (int i = 0; i < 4; i++) tbl.push_back(mk(16'h0028, 0, 1, 0, 1, 5, 0));
      // round-robin rotation
      tbl.push_back(mk(16'h8101, 1, 1, 0, 1, 15, 0));
      tbl.push_back(mk(16'h8101, 1, 1, 0, 1, 8, 0));
      tbl.push_back(mk(16'h8101, 1, 1, 0, 1, 0, 0));
      tbl.push_back(mk(16'h8101, 1, 1, 0, 1, 15, 0));
      tbl.push_back(mk(16'h8101, 1, 1, 0, 1, 8, 0));
      // drain, then backpressure with a sticky grant
      tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 8, 1));
      tbl.push_back(mk(16'h0080, 0, 0, 0, 1, 7, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(16'h8000, 0, 0, 0, 1, 7, 0));
      tbl.push_back(mk(16'h8000, 0, 1, 0, 1, 15, 0));
      // empty request then lowest line
      tbl.push_back(mk(16'h0000, 0, 1, 0, 0, 15, 1));
      tbl.push_back(mk(16'h0001, 0, 1, 0, 1, 0, 0));

      foreach (tbl[i]) begin
         string nm;
         nm = $sformatf("tbl%0d", i);
         step(0, 64'(tbl[i].req), tbl[i].mode, tbl[i].rdy, tbl[i].rst, nm);
         check_exp(0, tbl[i].exp_gv, tbl[i].exp_idx, tbl[i].exp_none, nm);
      end

      // N=5 round-robin with non-power-of-two wrap, then reset during hold
      step(1, 64'h00, 1, 1, 1, "n5_rst");
      check_exp(1, 0, 0, 1, "n5_rst");
      step(1, 64'h11, 1, 1, 0, "n5_rr0"); check_exp(1, 1, 4, 0, "n5_rr0");
      step(1, 64'h11, 1, 1, 0, "n5_rr1"); check_exp(1, 1, 0, 0, "n5_rr1");
      step(1, 64'h11, 1, 1, 0, "n5_rr2"); check_exp(1, 1, 4, 0, "n5_rr2");
      step(1, 64'h11, 1, 1, 0, "n5_rr3"); check_exp(1, 1, 0, 0, "n5_rr3");
      step(1, 64'h11, 1, 0, 0, "n5_hold"); check_exp(1, 1, 0, 0, "n5_hold");
      step(1, 64'h11, 1, 0, 1, "n5_rsthold"); check_exp(1, 0, 0, 1, "n5_rsthold");
      step(1, 64'h11, 1, 1, 0, "n5_after"); check_exp(1, 1, 4, 0, "n5_after");

      // randomized traffic on both instances
      for (int d = 0; d < 2; d++) begin
         bit md = 1'b0;
         step(d, 64'h0, 0, 0, 1, "rnd_rst");
         for (int i = 0; i < 600; i++) begin
            logic [63:0] r;
            bit rdy, rs;
            r = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
               0: r = '0;
               1: r = r & {$urandom(), $urandom()} & {$urandom(), $urandom()};
               default: ;
            endcase
            if ($urandom_range(0, 7) == 0) md = ~md;
            rdy = ($urandom_range(0, 3) != 0);
            rs  = ($urandom_range(0, 59) == 0);
            step(d, r, md, rdy, rs, $sformatf("rnd%0d_%0d", d, i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prio_arb_enc.md
Name: prio_arb_enc

Overview:
- Parametrised, registered successor to the 16-to-4 combinational priority encoder.
- Arbitrates N request lines and emits the winner as a binary index plus a one-hot grant, under a valid/ready handshake.
- Two run-time modes: fixed priority (highest index wins) and round-robin (rotating priority).
- Sits between raw request inputs (pins or upstream blocks) and a consumer that takes one grant per handshake.
- Replaces the old magic all-zero code (8'b11110000) with an explicit grant_valid.

Parameters:
- N, 16, number of request lines; legal range 2..64.
- IDX_W, $clog2(N), width of grant_idx; derived, never overridden.
- RR_EN, 1, when 0 round-robin logic is not built and mode is ignored (always fixed).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector, level-sensitive, sampled every cycle.
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only when a new arbitration occurs.
- grant_valid  output  1  registered; grant_idx/grant_onehot hold a grant.
- grant_ready  input  1  consumer accepts the grant when grant_valid and grant_ready are both 1.
- grant_idx  output  IDX_W  binary index of the granted line.
- grant_onehot  output  N  one-hot copy of grant_idx; zero when grant_valid=0.
- none  output  1  registered; 1 when the last arbitration saw req == 0.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - grant_valid=0, grant_idx=0, grant_onehot=0, none=1.
  - Round-robin pointer ptr=N-1.
  - Reset dominates every other input in that cycle.
- Arbitrate slot: a cycle where grant_valid=0, or grant_valid=1 and grant_ready=1.
- In an arbitrate slot:
  - Compute winner W from the current req and mode.
  - If req != 0: next cycle grant_valid=1, grant_idx=W, grant_onehot=1<<W, none=0.
  - If req == 0: next cycle grant_valid=0, grant_onehot=0, grant_idx keeps its old value, none=1.
- Latency: a request present in cycle t produces grant_valid in cycle t+1.
- Throughput: with grant_ready held at 1, one grant per cycle.
- Hold (grant_valid=1, grant_ready=0):
  - grant_idx, grant_onehot and grant_valid stay stable.
  - The grant is sticky: deasserting req[W] does not cancel it.
  - New or higher-priority requests wait.
- Fixed mode: W = highest set index of req. ptr is not updated.
- Round-robin mode:
  - Priority descends from ptr, wrapping from 0 to N-1.
  - W = highest set bit of req masked to indices <= ptr; if that mask is empty, highest set bit of unmasked req.
  - On each accepted handshake of a grant issued in RR mode: ptr = (W==0) ? N-1 : W-1.
- ptr starts at N-1, so the first RR grant after reset equals the fixed-priority result.
- Mode switch mid-stream: applies at the next arbitrate slot. A held grant is unaffected. ptr keeps its value across switches.
- Arithmetic: all index math is modulo N (no power-of-two assumption); wrap from 0 goes to N-1.
- Reset during hold: the grant is dropped with no handshake and ptr returns to N-1.
- Invariant: grant_onehot has exactly one bit set iff grant_valid=1.

Decomposition:
- Package prio_arb_pkg:
  - mode constants MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Function clog2-safe width helper.
- Sub-module prio_find_high (combinational):
  - Parameter N.
  - Input vec[N]; outputs idx[IDX_W] and found.
  - Highest-set-bit search.
  - Instantiated twice in RR (masked and unmasked), once when RR_EN=0.
- Top level holds only the registers, the ptr update, mask generation and handshake logic.

Test Plan:
1. N=16, rst=1 for 2 cycles with req=16'hFFFF -> grant_valid=0, grant_onehot=0, none=1. Release rst, ready=1 -> next cycle grant_idx=15, grant_onehot=16'h8000.
2. Fixed mode, req=16'h0028, ready=1 for 4 cycles -> grant_idx=5 every cycle, grant_valid continuously 1.
3. RR mode, req=16'h8101, ready=1 -> grant_idx sequence 15, 8, 0, 15, 8.
4. Backpressure, fixed mode: req=16'h0080, ready=0 -> grant_idx=7. Then req=16'h8000 for 3 cycles -> grant_idx stays 7, grant_onehot=16'h0080. Raise ready -> next grant_idx=15.
5. req=0 after one accepted grant -> grant_valid=0 and none=1 the following cycle. Then req=16'h0001 -> grant_idx=0, none=0 one cycle later.
6. N=5, RR mode, req=5'b10001, ready=1 -> 4, 0, 4, 0. Assert rst mid-hold with ready=0 -> grant_valid=0 next cycle, and first grant after release is 4.
